vn_mem_arbiter: RTL and testbench

- Shares one single-port synchronous read/write memory between the instruction-fetch port (read-only) and the load/store data port of the Von Neumann core.
- Each requester uses a valid/ready request channel and a valid/ready read-response channel.
- Ties are settled by 2-way round-robin; at most one read is in flight.
- Sits between the core front-end/LSU and the read/write memory instance.

---
 rtl/vn_mem_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/vn_mem_arbiter.sv | 119 +++++++++++
 tb/tb_vn_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vn_mem_pkg.sv
// Shared definitions for the Von Neumann memory arbiter.
// Contents: requester port ids and the arbiter FSM state encoding.
package vn_mem_pkg;

  // Requester ids; also used as bit positions in request/grant vectors.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : request bits, indexed by PORT_IF / PORT_D
//   i_update   : record the current grant as the last grant at the clock edge
//   o_grant    : one-hot (or zero) combinational grant
module rr_arbiter2
  import vn_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  logic r_last_grant;
  logic w_pick_d;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    w_pick_d = i_req[PORT_D] & (~i_req[PORT_IF] | (r_last_grant == PORT_IF));
    o_grant          = 2'b00;
    o_grant[PORT_D]  = w_pick_d;
    o_grant[PORT_IF] = i_req[PORT_IF] & ~w_pick_d;
  end

  // Reset to DATA so the first tie goes to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_D;
    end else if (i_update) begin
      r_last_grant <= o_grant[PORT_D] ? PORT_D : PORT_IF;
    end
  end

endmodule

// File: rtl/vn_mem_arbiter.sv
// Shares a single-port synchronous memory between the fetch port (read-only)
// and the load/store port. One read in flight at most; writes complete in
// the accept cycle and never produce a response.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   if_req_* / if_resp_*               : fetch request and read-response channels
//   d_req_* / d_resp_*                 : data request and load-response channels
//   mem_addr/rd_en/wr_en/wr_data       : memory command, valid in the accept cycle
//   mem_rd_data                        : memory read data, one cycle after rd_en
//   busy                               : read in flight or response pending
module vn_mem_arbiter
  import vn_mem_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DATA_DEPTH = 1024,
  localparam int unsigned AW         = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [AW-1:0]         if_req_addr,
  output logic                  if_resp_valid,
  input  logic                  if_resp_ready,
  output logic [DATA_WIDTH-1:0] if_resp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [AW-1:0]         d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_resp_valid,
  input  logic                  d_resp_ready,
  output logic [DATA_WIDTH-1:0] d_resp_data,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_idle;
  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_rd_acc;

  // Requests are only visible to the arbiter in IDLE and out of reset, so
  // ready, enables and last-grant updates are all suppressed otherwise.
  assign w_idle = (r_state == IDLE) & rst_n;

  always_comb begin
    w_req          = 2'b00;
    w_req[PORT_IF] = if_req_valid & w_idle;
    w_req[PORT_D]  = d_req_valid & w_idle;
  end

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_req),
    .i_update (|w_grant),
    .o_grant  (w_grant)
  );

  assign w_rd_acc = w_grant[PORT_IF] | (w_grant[PORT_D] & ~d_req_we);

  // Memory command mux and next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    if_req_ready = w_grant[PORT_IF];
    d_req_ready  = w_grant[PORT_D];
    mem_addr     = '0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_wr_data  = '0;

    if (w_grant[PORT_D]) begin
      mem_addr = d_req_addr;
      if (d_req_we) begin
        mem_wr_en   = 1'b1;
        mem_wr_data = d_req_wdata;
      end else begin
        mem_rd_en = 1'b1;
      end
    end else if (w_grant[PORT_IF]) begin
      mem_addr  = if_req_addr;
      mem_rd_en = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_rd_acc) begin
          w_state_nxt = w_grant[PORT_D] ? RESP_D : RESP_IF;
        end
      end
      RESP_IF: if (if_resp_ready) w_state_nxt = IDLE;
      RESP_D:  if (d_resp_ready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read data stays stable in RESP_* because no new read is issued there.
  assign if_resp_valid = (r_state == RESP_IF);
  assign d_resp_valid  = (r_state == RESP_D);
  assign if_resp_data  = if_resp_valid ? mem_rd_data : '0;
  assign d_resp_data   = d_resp_valid  ? mem_rd_data : '0;
  assign busy          = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

endmodule

// File: tb/tb_vn_mem_arbiter.sv
module tb_vn_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_resp_data;
  logic          d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_ready;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_resp_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en, busy;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;

  always #5 clk = ~clk;

  vn_mem_arbiter #(.DATA_WIDTH(DW), .DATA_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  // Memory instance the arbiter drives: synchronous, one-cycle read latency.
  logic [DW-1:0] env_mem [16] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_wr_en) env_mem[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= env_mem[mem_addr];
  end

  // Transaction-level reference: pending response, its data, and last winner.
  logic          m_pend = 1'b0;
  logic          m_port = 1'b0;
  logic          m_last = 1'b1;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_mem [16] = '{default: 32'h0};
  logic          e_if_rdy, e_d_rdy;

  assign e_if_rdy = rst_n && !m_pend && if_req_valid && (!d_req_valid || m_last == 1'b1);
  assign e_d_rdy  = rst_n && !m_pend && d_req_valid && (!if_req_valid || m_last == 1'b0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_last <= 1'b1;
    end else if (m_pend) begin
      if ((m_port == 1'b0 && if_resp_ready) || (m_port == 1'b1 && d_resp_ready)) m_pend <= 1'b0;
    end else if (e_if_rdy) begin
      m_last <= 1'b0;
      m_pend <= 1'b1;
      m_port <= 1'b0;
      m_data <= m_mem[if_req_addr];
    end else if (e_d_rdy) begin
      m_last <= 1'b1;
      if (d_req_we) begin
        m_mem[d_req_addr] <= d_req_wdata;
      end else begin
        m_pend <= 1'b1;
        m_port <= 1'b1;
        m_data <= m_mem[d_req_addr];
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  int            wr_cnt = 0;
  int            dresp_cnt = 0;
  bit            dut_grants[$];
  logic [DW-1:0] if_rq[$];
  logic [DW-1:0] d_rq[$];

  // Per-cycle compare against the model, plus observation logs.
  initial forever begin
    logic [AW-1:0] ea;
    @(negedge clk);
    ea = e_if_rdy ? if_req_addr : (e_d_rdy ? d_req_addr : '0);
    chk("if_req_ready", 32'(if_req_ready), 32'(e_if_rdy));
    chk("d_req_ready", 32'(d_req_ready), 32'(e_d_rdy));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(e_if_rdy || (e_d_rdy && !d_req_we)));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_d_rdy && d_req_we));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_wr_data", mem_wr_data, (e_d_rdy && d_req_we) ? d_req_wdata : 32'h0);
    chk("if_resp_valid", 32'(if_resp_valid), 32'(m_pend && m_port == 1'b0));
    chk("d_resp_valid", 32'(d_resp_valid), 32'(m_pend && m_port == 1'b1));
    chk("if_resp_data", if_resp_data, (m_pend && m_port == 1'b0) ? m_data : 32'h0);
    chk("d_resp_data", d_resp_data, (m_pend && m_port == 1'b1) ? m_data : 32'h0);
    chk("busy", 32'(busy), 32'(m_pend));
    if (rst_n) begin
      if (mem_wr_en) wr_cnt++;
      if (d_resp_valid) dresp_cnt++;
      if (if_req_valid && if_req_ready) dut_grants.push_back(1'b0);
      if (d_req_valid && d_req_ready) dut_grants.push_back(1'b1);
      if (if_resp_valid && if_resp_ready) if_rq.push_back(if_resp_data);
      if (d_resp_valid && d_resp_ready) d_rq.push_back(d_resp_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic issue(input bit port, input bit we, input int addr, input logic [DW-1:0] data);
    bit acc = 1'b0;
    if (port) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = AW'(addr); d_req_wdata = data;
    end else begin
      if_req_valid = 1'b1; if_req_addr = AW'(addr);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = port ? d_req_ready : if_req_ready;
      cyc();
      if (acc) break;
    end
    if (port) d_req_valid = 1'b0; else if_req_valid = 1'b0;
    if (!acc) chk("issue_timeout", 32'(acc), 32'd1);
  endtask

  task automatic get_resp(input bit port, output logic [DW-1:0] data);
    bit v = 1'b0;
    data = '0;
    if (port) d_resp_ready = 1'b1; else if_resp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      v    = port ? d_resp_valid : if_resp_valid;
      data = port ? d_resp_data : if_resp_data;
      cyc();
      if (v) break;
    end
    if (!v) chk("resp_timeout", 32'(v), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int w0, dr0, acc;
    logic [DW-1:0] stream_exp [8] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h44, 32'h11, 32'h22, 32'h77};
    bit            grant_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    if_req_valid = 0; if_req_addr = '0; if_resp_ready = 0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_resp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_d_resp_valid", 32'(d_resp_valid), 0);
    if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b1;
    #1;
    chk("rst_if_ready_forced", 32'(if_req_ready), 0);
    chk("rst_d_ready_forced", 32'(d_req_ready), 0);
    chk("rst_wr_en_forced", 32'(mem_wr_en), 0);
    chk("rst_rd_en_forced", 32'(mem_rd_en), 0);
    if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Write then read back through the data port.
    w0 = wr_cnt;
    issue(1'b1, 1'b1, 3, 32'hDEADBEEF);
    chk("t1_wr_pulses", 32'(wr_cnt - w0), 1);
    d_resp_ready = 1'b1;
    issue(1'b1, 1'b0, 3, 32'h0);
    @(negedge clk);
    chk("t1_resp_valid_lat1", 32'(d_resp_valid), 1);
    chk("t1_resp_data", d_resp_data, 32'hDEADBEEF);
    chk("t1_busy", 32'(busy), 1);
    cyc();
    @(negedge clk);
    chk("t1_busy_clear", 32'(busy), 0);
    cyc();

    issue(1'b1, 1'b1, 4, 32'h44);
    issue(1'b1, 1'b1, 5, 32'h11);
    issue(1'b1, 1'b1, 6, 32'h22);
    issue(1'b1, 1'b1, 7, 32'h77);

    // Both ports reading every cycle: grants alternate starting with fetch.
    dut_grants.delete(); if_rq.delete(); d_rq.delete();
    if_resp_ready = 1'b1; d_resp_ready = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 4'd5;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 4'd6;
    repeat (8) cyc();
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    chk("t2_grant_count", 32'(dut_grants.size()), 4);
    foreach (dut_grants[i]) if (i < 4) chk("t2_grant_order", 32'(dut_grants[i]), 32'(grant_exp[i]));
    chk("t2_if_resp_count", 32'(if_rq.size()), 2);
    chk("t2_d_resp_count", 32'(d_rq.size()), 2);
    foreach (if_rq[i]) chk("t2_if_data", if_rq[i], 32'h11);
    foreach (d_rq[i]) chk("t2_d_data", d_rq[i], 32'h22);
    repeat (2) cyc();

    // Load response back-pressured for several cycles.
    d_resp_ready = 1'b0;
    issue(1'b1, 1'b0, 6, 32'h0);
    if_req_valid = 1'b1; if_req_addr = 4'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(d_resp_valid), 1);
      chk("t3_hold_data", d_resp_data, 32'h22);
      chk("t3_if_ready_low", 32'(if_req_ready), 0);
      chk("t3_d_ready_low", 32'(d_req_ready), 0);
      cyc();
    end
    d_resp_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_at_handshake", 32'(d_resp_valid), 1);
    cyc();
    @(negedge clk);
    chk("t3_idle_after", 32'(busy), 0);
    chk("t3_if_granted", 32'(if_req_ready), 1);
    cyc();
    if_req_valid = 1'b0;
    repeat (2) cyc();

    // Back-to-back writes, one per cycle, no load responses.
    w0 = wr_cnt; dr0 = dresp_cnt;
    d_req_valid = 1'b1; d_req_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_req_addr = AW'(i); d_req_wdata = 32'(i + 1);
      @(negedge clk);
      chk("t4_wr_ready", 32'(d_req_ready), 1);
      cyc();
    end
    d_req_valid = 1'b0; d_req_we = 1'b0;
    chk("t4_wr_pulses", 32'(wr_cnt - w0), 4);
    chk("t4_no_d_resp", 32'(dresp_cnt - dr0), 0);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, i, 32'h0);
      get_resp(1'b0, rd);
      chk("t4_readback", rd, 32'(i + 1));
    end

    // Asynchronous reset while a fetch response is pending.
    if_resp_ready = 1'b0;
    issue(1'b0, 1'b0, 5, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_if_valid_drop", 32'(if_resp_valid), 0);
    chk("t5_busy_drop", 32'(busy), 0);
    chk("t5_if_data_zero", if_resp_data, 32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    if_resp_ready = 1'b1;
    cyc();
    issue(1'b0, 1'b0, 5, 32'h0);
    get_resp(1'b0, rd);
    chk("t5_after_reset_read", rd, 32'h11);

    // Fetch-only stream: grant every other cycle, responses in address order.
    if_rq.delete();
    acc = 0;
    if_resp_ready = 1'b1; if_req_valid = 1'b1; if_req_addr = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("t6_stream_ready", 32'(if_req_ready), 32'((c % 2) == 0));
      if (if_req_ready) acc++;
      cyc();
      if (acc == 8) if_req_valid = 1'b0; else if_req_addr = AW'(acc);
    end
    if_req_valid = 1'b0;
    chk("t6_accepts", 32'(acc), 8);
    chk("t6_resp_count", 32'(if_rq.size()), 8);
    foreach (if_rq[i]) if (i < 8) chk("t6_resp_data", if_rq[i], stream_exp[i]);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit a_if, a_d;
      @(negedge clk);
      a_if = if_req_valid && if_req_ready;
      a_d  = d_req_valid && d_req_ready;
      cyc();
      if (!if_req_valid || a_if) begin
        if_req_valid = 1'($urandom_range(0, 1));
        if_req_addr  = AW'($urandom_range(0, 15));
      end
      if (!d_req_valid || a_d) begin
        d_req_valid = 1'($urandom_range(0, 1));
        d_req_we    = 1'($urandom_range(0, 1));
        d_req_addr  = AW'($urandom_range(0, 15));
        d_req_wdata = $urandom;
      end
      if_resp_ready = ($urandom_range(0, 3) != 0);
      d_resp_ready  = ($urandom_range(0, 3) != 0);
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    if_resp_ready = 1'b1; d_resp_ready = 1'b1;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
